lab61soc_key_input_pio: RTL and testbench
=========================================

Name: lab61soc_key_input_pio

Overview:
- Avalon-MM slave input port, the read-side counterpart to the SoC's single-bit output PIO.
- Samples WIDTH asynchronous active-low push-buttons (e.g. Reset/Accumulate keys).
- Synchronises and debounces each bit, then latches press events in an edge-capture register.
- Raises a maskable level interrupt to the Nios II, which reads key levels and clears events over the same 2-bit-address slave interface.

Parameters:
- WIDTH, 2, number of input bits (1..32).
- DEBOUNCE_CYCLES, 500000, clk cycles a synchronised level must hold before acceptance (10 ms at 50 MHz); minimum 1.
- CNT_W, 19, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- address  input  2  register select.
- chipselect  input  1  slave select.
- write_n  input  1  active-low write strobe.
- writedata  input  32  write data.
- readdata  output  32  read data, combinational, read latency 0.
- in_port  input  WIDTH  raw asynchronous key inputs, active-low (1 = released).
- irq  output  1  level interrupt, active-high.

Behaviour:
- Reset: reset is reset_n, asynchronous, active-low; clock is clk. All flops reset asynchronously:
  - sync1/sync2 and stable reset to all-ones (released).
  - Debounce counters, interruptmask and edgecapture reset to 0.
  - irq = 0; readdata = 0 unless selected per the register map.
- Reset asserted mid-debounce or with pending events discards all state. Keys held low across reset release are accepted as new presses after the normal latency.
- Synchroniser: 2 flops per bit, in_port -> sync1 -> sync2. No logic between the stages.
- Debounce, independently per bit i:
  - If sync2[i] == stable[i], cnt[i] <= 0.
  - Else if cnt[i] == DEBOUNCE_CYCLES-1, stable[i] <= sync2[i] and cnt[i] <= 0.
  - Else cnt[i] <= cnt[i]+1.
  - A glitch shorter than DEBOUNCE_CYCLES cycles at sync2 produces no stable change.
  - Latency from in_port edge to stable change is 2 + DEBOUNCE_CYCLES clk edges.
- Press event: on the edge where stable[i] commits 1->0, edgecapture[i] <= 1 on that same edge. Release (0->1) sets nothing.
- Register map (readdata bits above WIDTH are always 0):
  - 0 data: read returns ~stable (1 = pressed). Writes ignored.
  - 1 reserved: reads 0, writes ignored.
  - 2 interruptmask: read/write, bits [WIDTH-1:0].
  - 3 edgecapture: read returns the register; a write clears each bit where writedata[i]=1 (write-1-to-clear); bits with writedata[i]=0 are unchanged.
- A write occurs when chipselect && !write_n. A read is any cycle with chipselect; reads have no side effects.
- Set and clear of the same edgecapture bit in the same cycle: set wins, bit stays 1.
- irq = |(edgecapture & interruptmask), driven combinationally from registers.
  - Deasserts the cycle after a clearing write or a mask write of 0.
  - Asserts the cycle after a mask write that enables a pending bit.
- The counter never exceeds DEBOUNCE_CYCLES-1, so there is no wrap-around.

Test Plan (bench uses DEBOUNCE_CYCLES=4, WIDTH=2):
- Press: drive in_port=2'b10 from reset -> data reads 2'b01 exactly 6 edges later; edgecapture=2'b01; irq=0 because the mask is 0.
- Interrupt path: write mask=2'b01, then press bit 0 -> irq=1 on the capture edge. Write 0x1 to address 3 -> edgecapture=0 and irq=0 next cycle.
- Glitch rejection: pulse in_port[1] low for 3 cycles -> data and edgecapture stay 0, irq stays 0. A 4-cycle low at sync2 is accepted.
- Release: release a held key -> data bit returns to 0 after 6 edges; edgecapture is unchanged.
- Simultaneous set and clear: time a W1C write to address 3 with data 0x3 on the same edge bit 1 commits a press -> edgecapture=2'b10, bit 0 cleared.
- Mid-operation reset: assert reset_n=0 during a pending debounce count with edgecapture=2'b11 -> all registers 0 and irq=0 immediately (asynchronous). A held key is recaptured 6 edges after release of reset.

Source files
------------

// File: rtl/lab61soc_key_input_pio_if.sv
// Avalon-MM slave bus bundle for the key input PIO: 2-bit register select,
// active-low write strobe, 32-bit data paths.
interface lab61soc_key_input_pio_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/lab61soc_key_input_pio.sv
// Debounced active-low key input port with press edge-capture and a maskable
// level interrupt, read and cleared over an Avalon-MM slave.
module lab61soc_key_input_pio #(
  parameter int WIDTH           = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19
) (
  input  logic                      clk,
  input  logic                      reset_n,
  lab61soc_key_input_pio_if.slave   bus,
  input  logic [WIDTH-1:0]          in_port,
  output logic                      irq
);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [1:0]       ADDR_DATA = 2'd0;
  localparam logic [1:0]       ADDR_RSVD = 2'd1;
  localparam logic [1:0]       ADDR_MASK = 2'd2;
  localparam logic [1:0]       ADDR_EDGE = 2'd3;

  logic [WIDTH-1:0] sync1_r;
  logic [WIDTH-1:0] sync2_r;
  logic [WIDTH-1:0] stable_r;
  logic [WIDTH-1:0] interruptmask_r;
  logic [WIDTH-1:0] edgecapture_r;
  logic [CNT_W-1:0] cnt_r [WIDTH];

  logic [WIDTH-1:0] commit_s;
  logic [WIDTH-1:0] press_s;
  logic [WIDTH-1:0] clear_s;
  logic             wr_s;
  logic [31:0]      rdata_s;
  logic             unused_wdata_s;

  assign wr_s           = bus.chipselect && !bus.write_n;
  assign unused_wdata_s = ^bus.writedata;

  // A bit commits when it has disagreed with the accepted level for the full window.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      commit_s[i] = (sync2_r[i] != stable_r[i]) && (cnt_r[i] == CNT_LAST);
    end
  end

  // Only a 1->0 commit of the accepted level is a press.
  assign press_s = commit_s & stable_r;

  // Write-1-to-clear mask for the edge-capture register.
  always_comb begin
    if (wr_s && (bus.address == ADDR_EDGE)) begin
      clear_s = bus.writedata[WIDTH-1:0];
    end else begin
      clear_s = {WIDTH{1'b0}};
    end
  end

  // Two-flop synchroniser; resets to the released level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_r <= {WIDTH{1'b1}};
      sync2_r <= {WIDTH{1'b1}};
    end else begin
      sync1_r <= in_port;
      sync2_r <= sync1_r;
    end
  end

  // Per-bit debounce counters and accepted key levels.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable_r <= {WIDTH{1'b1}};
      for (int i = 0; i < WIDTH; i++) begin
        cnt_r[i] <= {CNT_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync2_r[i] == stable_r[i]) begin
          cnt_r[i] <= {CNT_W{1'b0}};
        end else if (commit_s[i]) begin
          stable_r[i] <= sync2_r[i];
          cnt_r[i]    <= {CNT_W{1'b0}};
        end else begin
          cnt_r[i] <= cnt_r[i] + CNT_W'(1'b1);
        end
      end
    end
  end

  // Interrupt mask register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      interruptmask_r <= {WIDTH{1'b0}};
    end else if (wr_s && (bus.address == ADDR_MASK)) begin
      interruptmask_r <= bus.writedata[WIDTH-1:0];
    end
  end

  // Edge capture: a press on the same edge as a clear keeps the bit set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edgecapture_r <= {WIDTH{1'b0}};
    end else begin
      edgecapture_r <= (edgecapture_r & ~clear_s) | press_s;
    end
  end

  // Zero-latency read mux; unselected or reserved reads return zero.
  always_comb begin
    rdata_s = 32'd0;
    if (bus.chipselect) begin
      case (bus.address)
        ADDR_DATA: rdata_s[WIDTH-1:0] = ~stable_r;
        ADDR_RSVD: rdata_s            = 32'd0;
        ADDR_MASK: rdata_s[WIDTH-1:0] = interruptmask_r;
        ADDR_EDGE: rdata_s[WIDTH-1:0] = edgecapture_r;
        default:   rdata_s            = 32'd0;
      endcase
    end else begin
      rdata_s = 32'd0;
    end
  end

  assign bus.readdata = rdata_s;
  assign irq          = |(edgecapture_r & interruptmask_r);

endmodule

// File: tb/tb_lab61soc_key_input_pio.sv
// Scoreboard bench for the key input PIO with a 4-cycle debounce window:
// expectations are queued as stimulus is driven and checked on drain.
`timescale 1ns/1ps
module tb_lab61soc_key_input_pio;

  localparam int SEL_IRQ = 4;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  logic       clk;
  logic       reset_n;
  logic [1:0] in_port;
  logic       irq;
  int         vectors_applied;
  int         miscompares;
  exp_t       sb[$];

  lab61soc_key_input_pio_if bus ();

  lab61soc_key_input_pio #(
    .WIDTH          (2),
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (3)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus.slave),
    .in_port(in_port),
    .irq    (irq)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors_applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_val(input string tag, input int sel, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.sel == SEL_IRQ) begin
        check_eq(e.tag, {31'd0, irq}, e.exp);
      end else begin
        bus.address    = 2'(e.sel);
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b1;
        #1;
        check_eq(e.tag, bus.readdata, e.exp);
        bus.chipselect = 1'b0;
      end
    end
  endtask

  task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
    bus.address    = addr;
    bus.writedata  = data;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    tick(1);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = 32'd0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vectors_applied = 0;
    miscompares     = 0;
    reset_n         = 1'b0;
    in_port         = 2'b11;
    bus.address     = 2'd0;
    bus.chipselect  = 1'b0;
    bus.write_n     = 1'b1;
    bus.writedata   = 32'd0;
    tick(2);
    expect_val("rst_data", 0, 32'd0);
    expect_val("rst_rsvd", 1, 32'd0);
    expect_val("rst_mask", 2, 32'd0);
    expect_val("rst_edge", 3, 32'd0);
    expect_val("rst_irq", SEL_IRQ, 32'd0);
    drain();
    reset_n = 1'b1;

    // Press bit 0: accepted on the sixth edge, irq stays low with mask 0
    in_port = 2'b10;
    tick(5);
    expect_val("press_early_data", 0, 32'd0);
    drain();
    tick(1);
    expect_val("press_data", 0, 32'd1);
    expect_val("press_edge", 3, 32'd1);
    expect_val("press_irq", SEL_IRQ, 32'd0);
    drain();

    // Release: data drops after six edges, capture untouched
    in_port = 2'b11;
    tick(5);
    expect_val("rel_early_data", 0, 32'd1);
    drain();
    tick(1);
    expect_val("rel_data", 0, 32'd0);
    expect_val("rel_edge", 3, 32'd1);
    drain();

    // Interrupt path through the mask and write-1-to-clear
    bus_write(2'd3, 32'd1);
    expect_val("w1c_edge", 3, 32'd0);
    expect_val("w1c_irq", SEL_IRQ, 32'd0);
    drain();
    bus_write(2'd2, 32'd1);
    bus_write(2'd0, 32'hffff_ffff);
    bus_write(2'd1, 32'hffff_ffff);
    expect_val("mask_rd", 2, 32'd1);
    expect_val("data_wr_ignored", 0, 32'd0);
    expect_val("rsvd_wr_ignored", 1, 32'd0);
    drain();
    in_port = 2'b10;
    tick(5);
    expect_val("irq_before_cap", SEL_IRQ, 32'd0);
    drain();
    tick(1);
    expect_val("irq_on_cap", SEL_IRQ, 32'd1);
    expect_val("irq_cap_edge", 3, 32'd1);
    drain();
    bus_write(2'd2, 32'd0);
    expect_val("irq_mask_off", SEL_IRQ, 32'd0);
    drain();
    bus_write(2'd2, 32'd1);
    expect_val("irq_mask_on", SEL_IRQ, 32'd1);
    drain();
    bus_write(2'd3, 32'd1);
    expect_val("irq_clr", SEL_IRQ, 32'd0);
    expect_val("irq_clr_edge", 3, 32'd0);
    drain();
    bus_write(2'd2, 32'd3);

    // Glitch of 3 cycles on bit 1 is rejected
    in_port = 2'b00;
    tick(3);
    in_port = 2'b10;
    tick(8);
    expect_val("glitch_data", 0, 32'd1);
    expect_val("glitch_edge", 3, 32'd0);
    expect_val("glitch_irq", SEL_IRQ, 32'd0);
    drain();

    // A 4-cycle low is accepted, then its release follows
    in_port = 2'b00;
    tick(4);
    in_port = 2'b10;
    tick(2);
    expect_val("pulse4_data", 0, 32'd3);
    expect_val("pulse4_edge", 3, 32'd2);
    expect_val("pulse4_irq", SEL_IRQ, 32'd1);
    drain();
    tick(3);
    expect_val("pulse4_hold_data", 0, 32'd3);
    drain();
    tick(1);
    expect_val("pulse4_rel_data", 0, 32'd1);
    expect_val("pulse4_rel_edge", 3, 32'd2);
    drain();

    // Clear on the same edge bit 1 commits a press: set wins, bit 0 clears
    bus_write(2'd3, 32'd3);
    expect_val("pre_sim_edge", 3, 32'd0);
    drain();
    in_port = 2'b11;
    tick(6);
    in_port = 2'b10;
    tick(6);
    expect_val("pre_sim_edge1", 3, 32'd1);
    drain();
    in_port = 2'b00;
    tick(5);
    bus_write(2'd3, 32'd3);
    expect_val("sim_edge", 3, 32'd2);
    expect_val("sim_data", 0, 32'd3);
    expect_val("sim_irq", SEL_IRQ, 32'd1);
    drain();

    // Reset during a pending count with both capture bits set
    in_port = 2'b01;
    tick(6);
    expect_val("pre_rst_data", 0, 32'd2);
    drain();
    in_port = 2'b00;
    tick(6);
    expect_val("pre_rst_edge", 3, 32'd3);
    drain();
    in_port = 2'b10;
    tick(3);
    reset_n = 1'b0;
    #1;
    expect_val("mid_rst_irq", SEL_IRQ, 32'd0);
    expect_val("mid_rst_data", 0, 32'd0);
    expect_val("mid_rst_mask", 2, 32'd0);
    expect_val("mid_rst_edge", 3, 32'd0);
    drain();
    tick(2);
    reset_n = 1'b1;
    tick(5);
    expect_val("recap_early_data", 0, 32'd0);
    drain();
    tick(1);
    expect_val("recap_data", 0, 32'd1);
    expect_val("recap_edge", 3, 32'd1);
    expect_val("recap_irq", SEL_IRQ, 32'd0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
